// File: rtl/bin_batch_arbiter_if.sv
// bin_batch_arbiter_if
//   Request/grant and output handshake bundle for the bin-manager batch
//   arbiter.
//   master : arbiter side (drives grant/output/status, samples requests)
//   slave  : requester/downstream side (drives requests, data and ready)
// Signals:
//   req_i        [NUM]        request per requester
//   data_i       [NUM*WIDTH]  requester k data at [k*WIDTH +: WIDTH]
//   grant_o      [NUM]        one-hot accept strobe (combinational)
//   data_o       [WIDTH]      registered output data
//   valid_o                   data_o holds an unconsumed entry
//   ready_i                   downstream accepts data_o
//   busy_o                    a batch is being served
//   batch_done_o              one-cycle pulse after a batch ends
//   served_cnt_o [CNT_W]      grants issued in the current/last batch
interface bin_batch_arbiter_if #(
  parameter int NUM   = 8,
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(NUM) + 1
);
  logic [NUM-1:0]       req_i;
  logic [NUM*WIDTH-1:0] data_i;
  logic [NUM-1:0]       grant_o;
  logic [WIDTH-1:0]     data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 busy_o;
  logic                 batch_done_o;
  logic [CNT_W-1:0]     served_cnt_o;

  modport master (
    input  req_i, data_i, ready_i,
    output grant_o, data_o, valid_o, busy_o, batch_done_o, served_cnt_o
  );

  modport slave (
    output req_i, data_i, ready_i,
    input  grant_o, data_o, valid_o, busy_o, batch_done_o, served_cnt_o
  );
endinterface

// File: rtl/bin_batch_arbiter.sv
// bin_batch_arbiter
//   Shares one WIDTH-bit output channel among NUM requesters. Active
//   requests are snapshotted into a batch while idle, then served
//   lowest-index-first, one per cycle, into a 1-entry registered output
//   with a valid/ready handshake. Requests arriving mid-batch wait for the
//   next batch.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - bin_batch_arbiter_if.master (requests, grant, output, status)
module bin_batch_arbiter #(
  parameter int NUM   = 8,
  parameter int WIDTH = 5,
  parameter int CNT_W = $clog2(NUM) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bin_batch_arbiter_if.master  bus
);
  localparam int IDX_W = $clog2(NUM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
  } state_t;

  state_t            state_r;
  logic [NUM-1:0]    pending_r;
  logic [WIDTH-1:0]  data_r;
  logic              valid_r;
  logic              done_pend_r;
  logic              batch_done_r;
  logic [CNT_W-1:0]  served_r;

  logic [NUM-1:0]    live_s;
  logic [NUM-1:0]    onehot_s;
  logic [NUM-1:0]    remain_s;
  logic [NUM-1:0]    grant_s;
  logic [IDX_W-1:0]  sel_s;
  logic [WIDTH-1:0]  sel_data_s;
  logic              load_s;

  // Withdrawn requests drop out of the batch; the output slot can take a
  // new entry when empty or being drained this cycle.
  assign live_s     = pending_r & bus.req_i;
  assign load_s     = !valid_r || bus.ready_i;
  assign onehot_s   = {{(NUM-1){1'b0}}, 1'b1} << sel_s;
  assign remain_s   = live_s & ~onehot_s;
  assign sel_data_s = bus.data_i[sel_s*WIDTH +: WIDTH];

  // Lowest-index live requester; scanning downward lets the lowest win.
  always_comb begin
    sel_s = {IDX_W{1'b0}};
    for (int i = NUM - 1; i >= 0; i--) begin
      if (live_s[i]) begin
        sel_s = IDX_W'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Grant strobe: only while serving a batch and the output slot can load.
  always_comb begin
    grant_s = {NUM{1'b0}};
    if (!rst && (state_r == ST_BUSY) && (live_s != {NUM{1'b0}}) && load_s) begin
      grant_s = onehot_s;
    end else begin
      grant_s = {NUM{1'b0}};
    end
  end

  // Batch FSM, pending snapshot, output register and status counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pending_r    <= {NUM{1'b0}};
      data_r       <= {WIDTH{1'b0}};
      valid_r      <= 1'b0;
      done_pend_r  <= 1'b0;
      batch_done_r <= 1'b0;
      served_r     <= {CNT_W{1'b0}};
    end else begin
      // Batch end is flagged first, then presented as a one-cycle pulse.
      batch_done_r <= done_pend_r;
      done_pend_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_r && bus.ready_i) begin
            valid_r <= 1'b0;
          end
          if (bus.req_i != {NUM{1'b0}}) begin
            pending_r <= bus.req_i;
            served_r  <= {CNT_W{1'b0}};
            state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (live_s == {NUM{1'b0}}) begin
            // Everything withdrawn: end the batch without a grant.
            state_r     <= ST_IDLE;
            pending_r   <= {NUM{1'b0}};
            done_pend_r <= 1'b1;
            if (valid_r && bus.ready_i) begin
              valid_r <= 1'b0;
            end
          end else if (load_s) begin
            data_r    <= sel_data_s;
            valid_r   <= 1'b1;
            pending_r <= remain_s;
            served_r  <= served_r + CNT_W'(1);
            if (remain_s == {NUM{1'b0}}) begin
              state_r     <= ST_IDLE;
              done_pend_r <= 1'b1;
            end
          end else begin
            // Output stalled: keep the batch but forget withdrawn requests.
            pending_r <= live_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          pending_r <= {NUM{1'b0}};
        end
      endcase
    end
  end

  assign bus.grant_o      = grant_s;
  assign bus.data_o       = data_r;
  assign bus.valid_o      = valid_r;
  assign bus.busy_o       = (state_r == ST_BUSY);
  assign bus.batch_done_o = batch_done_r;
  assign bus.served_cnt_o = served_r;
endmodule

// File: tb/tb_bin_batch_arbiter.sv
// tb_bin_batch_arbiter
//   Directed bench for bin_batch_arbiter (NUM=8, WIDTH=5). Requester k
//   presents data k+10; a requester drops its request the cycle after it
//   is granted. Cycle 0 of each scenario is the idle cycle in which the
//   request set is sampled.
module tb_bin_batch_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bin_batch_arbiter_if #(.NUM(8), .WIDTH(5)) bus ();

  bin_batch_arbiter #(.NUM(8), .WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; granted requesters withdraw their request.
  task automatic cyc();
    logic [7:0] g;
    g = bus.grant_o;
    @(posedge clk);
    #1;
    bus.req_i = bus.req_i & ~g;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    errors = 0;
    checks = 0;
    bus.req_i   = 8'h00;
    bus.ready_i = 1'b1;
    for (int k = 0; k < 8; k++) bus.data_i[k*5 +: 5] = 5'(k + 10);

    // Reset state
    cyc(); cyc(); settle();
    chk("rst_grant", bus.grant_o, 8'h00);
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_data", bus.data_o, 5'd0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.batch_done_o, 1'b0);
    chk("rst_cnt", bus.served_cnt_o, 4'd0);
    cyc(); rst = 1'b0; settle();

    // 1: batch {2,5,7}, ready held high
    cyc(); bus.req_i = 8'hA4; settle();
    chk("t1_c0_grant", bus.grant_o, 8'h00);
    cyc(); settle();
    chk("t1_c1_grant", bus.grant_o, 8'h04);
    chk("t1_c1_busy", bus.busy_o, 1'b1);
    chk("t1_c1_valid", bus.valid_o, 1'b0);
    cyc(); settle();
    chk("t1_c2_grant", bus.grant_o, 8'h20);
    chk("t1_c2_data", bus.data_o, 5'd12);
    chk("t1_c2_valid", bus.valid_o, 1'b1);
    cyc(); settle();
    chk("t1_c3_grant", bus.grant_o, 8'h80);
    chk("t1_c3_data", bus.data_o, 5'd15);
    cyc(); settle();
    chk("t1_c4_grant", bus.grant_o, 8'h00);
    chk("t1_c4_data", bus.data_o, 5'd17);
    chk("t1_c4_busy", bus.busy_o, 1'b0);
    chk("t1_c4_done", bus.batch_done_o, 1'b0);
    cyc(); settle();
    chk("t1_c5_done", bus.batch_done_o, 1'b1);
    chk("t1_c5_cnt", bus.served_cnt_o, 4'd3);
    chk("t1_c5_valid", bus.valid_o, 1'b0);

    // 2: same batch, downstream stalls in cycles 2-4
    cyc(); bus.req_i = 8'hA4; settle();
    chk("t2_c0_done", bus.batch_done_o, 1'b0);
    cyc(); settle();
    chk("t2_c1_grant", bus.grant_o, 8'h04);
    for (int c = 2; c <= 4; c++) begin
      cyc(); bus.ready_i = 1'b0; settle();
      chk("t2_stall_grant", bus.grant_o, 8'h00);
      chk("t2_stall_data", bus.data_o, 5'd12);
      chk("t2_stall_valid", bus.valid_o, 1'b1);
    end
    cyc(); bus.ready_i = 1'b1; settle();
    chk("t2_c5_grant", bus.grant_o, 8'h20);
    chk("t2_c5_data", bus.data_o, 5'd12);
    cyc(); settle();
    chk("t2_c6_grant", bus.grant_o, 8'h80);
    chk("t2_c6_data", bus.data_o, 5'd15);
    cyc(); settle();
    chk("t2_c7_data", bus.data_o, 5'd17);
    chk("t2_c7_busy", bus.busy_o, 1'b0);
    cyc(); settle();
    chk("t2_c8_done", bus.batch_done_o, 1'b1);
    chk("t2_c8_cnt", bus.served_cnt_o, 4'd3);

    // 3: requester 5 withdraws in cycle 1
    cyc(); bus.req_i = 8'hA4; settle();
    cyc(); bus.req_i = bus.req_i & 8'hDF; settle();
    chk("t3_c1_grant", bus.grant_o, 8'h04);
    cyc(); settle();
    chk("t3_c2_grant", bus.grant_o, 8'h80);
    chk("t3_c2_data", bus.data_o, 5'd12);
    cyc(); settle();
    chk("t3_c3_grant", bus.grant_o, 8'h00);
    chk("t3_c3_data", bus.data_o, 5'd17);
    chk("t3_c3_cnt", bus.served_cnt_o, 4'd2);
    cyc(); settle();
    chk("t3_c4_done", bus.batch_done_o, 1'b1);

    // 4: batch {2}, requester 0 arrives mid-batch
    cyc(); bus.req_i = 8'h04; settle();
    cyc(); bus.req_i = bus.req_i | 8'h01; settle();
    chk("t4_c1_grant", bus.grant_o, 8'h04);
    cyc(); settle();
    chk("t4_c2_grant", bus.grant_o, 8'h00);
    chk("t4_c2_busy", bus.busy_o, 1'b0);
    cyc(); settle();
    chk("t4_c3_grant", bus.grant_o, 8'h01);
    chk("t4_c3_done", bus.batch_done_o, 1'b1);
    cyc(); settle();
    chk("t4_c4_data", bus.data_o, 5'd10);
    chk("t4_c4_done", bus.batch_done_o, 1'b0);
    cyc(); settle();
    chk("t4_c5_done", bus.batch_done_o, 1'b1);
    chk("t4_c5_cnt", bus.served_cnt_o, 4'd1);

    // 5: only the top requester, then all eight
    cyc(); bus.req_i = 8'h80; settle();
    cyc(); settle();
    chk("t5_c1_grant", bus.grant_o, 8'h80);
    cyc(); bus.req_i = 8'hFF; settle();
    chk("t5_c2_data", bus.data_o, 5'd17);
    chk("t5_c2_cnt", bus.served_cnt_o, 4'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(); settle();
      chk("t5_all_grant", bus.grant_o, 8'h01 << i);
      if (i == 0) chk("t5_first_done", bus.batch_done_o, 1'b1);
      if (i > 0) chk("t5_all_data", bus.data_o, 10 + i - 1);
    end
    cyc(); settle();
    chk("t5_end_data", bus.data_o, 5'd17);
    chk("t5_end_cnt", bus.served_cnt_o, 4'd8);
    chk("t5_end_grant", bus.grant_o, 8'h00);
    cyc(); settle();
    chk("t5_end_done", bus.batch_done_o, 1'b1);

    // 6: reset mid-batch after one grant
    cyc(); bus.req_i = 8'h0C; settle();
    cyc(); settle();
    chk("t6_c1_grant", bus.grant_o, 8'h04);
    cyc(); rst = 1'b1; settle();
    chk("t6_rst_grant", bus.grant_o, 8'h00);
    cyc(); rst = 1'b0; settle();
    chk("t6_c3_valid", bus.valid_o, 1'b0);
    chk("t6_c3_data", bus.data_o, 5'd0);
    chk("t6_c3_busy", bus.busy_o, 1'b0);
    chk("t6_c3_cnt", bus.served_cnt_o, 4'd0);
    chk("t6_c3_grant", bus.grant_o, 8'h00);
    cyc(); settle();
    chk("t6_c4_grant", bus.grant_o, 8'h08);
    cyc(); settle();
    chk("t6_c5_data", bus.data_o, 5'd13);
    chk("t6_c5_cnt", bus.served_cnt_o, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
